fsm_input_queue: RTL and testbench
==================================

# fsm_input_queue

Upstream feeder for the microcoded sequencer.
- Buffers 2-bit dispatch codes from a producer in a small FIFO.
- Drives the head entry onto the sequencer's `inp` bus.
- Pops one entry each time the sequencer's current state is a dispatch state, so each dispatch-ROM lookup consumes exactly one queued code.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- DISP_A, 4'b0011, first sequencer state that samples `inp` (dispatch ROM 1)
- DISP_B, 4'b1010, second sequencer state that samples `inp` (dispatch ROM 2)
- EMPTY_CODE, 2'b00, value driven on `inp` while the queue is empty

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- push_valid  in  1  producer has a code
- push_data  in  2  code to enqueue
- push_ready  out  1  queue can accept; equals !full
- fsm_state  in  4  sequencer current state (its `out` bus)
- inp  out  2  head code to sequencer `inp`; EMPTY_CODE when empty
- count  out  log2(DEPTH)+1  entries held
- empty  out  1  count==0
- full  out  1  count==DEPTH
- underflow  out  1  sticky; set on a pop attempt while empty

## Operation
- Push: occurs on a posedge when push_valid && push_ready. push_data is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop request is combinational: pop_req = (fsm_state==DISP_A) || (fsm_state==DISP_B).
- Pop: occurs on a posedge when pop_req && !empty. The read pointer increments modulo DEPTH.
- `inp` is combinational from the head register: mem[rd_ptr] when !empty, else EMPTY_CODE. The sequencer therefore sees the head on the same edge that pops it.
- Pop while empty (pop_req && empty):
  - pointers unchanged;
  - underflow set to 1 and held until rst;
  - the sequencer consumes EMPTY_CODE.
- Push and pop on the same edge, not empty and not full: both are performed and count is unchanged.
- Push and pop on the same edge when empty: the push is performed, the pop is an underflow, count becomes 1, and the new entry is not consumed.
- Full: push_ready=0 and no write occurs. This holds even when a pop occurs on the same edge; push_ready has no combinational dependence on fsm_state.
- Pointers are log2(DEPTH) bits and wrap naturally. count is tracked separately, with width log2(DEPTH)+1.

## Timing
- Reset, asynchronous: rd_ptr=wr_ptr=0, count=0, underflow=0.
  - Resulting outputs: empty=1, full=0, push_ready=1, inp=EMPTY_CODE.
  - Memory contents are not reset.
- rst asserted mid-operation: all queued entries are discarded immediately, with no wait for a clock edge. The first accepted push is possible on the first posedge after rst deasserts.
- Latency: a code pushed at edge N is visible on `inp` after edge N if the queue was empty. It can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle.
- fsm_state is sampled only at posedge. When the sequencer updates state with a delay after the edge, the queue samples the pre-edge state value, the same value the sequencer branches on.

## Configuration
- Macro FSM_INPUT_QUEUE_BYPASS_EN.
- Defined: when empty and push_valid=1, `inp` drives push_data combinationally. If pop_req is also 1 on that edge, the code is consumed directly:
  - no write, count stays 0;
  - no underflow.
- Not defined: no bypass path. An empty pop always yields EMPTY_CODE and sets underflow, per Operation.

## Test plan
- Reset sequence: assert rst mid-clock with 3 entries queued -> immediately count=0, empty=1, inp=2'b00, underflow=0. After release, push 2'b10 -> inp=2'b10, count=1.
- Fill/backpressure: push 2'b01, 2'b10, 2'b11, 2'b01 with fsm_state=4'b0000:
  - after the fourth push, full=1 and push_ready=0;
  - a fifth push of 2'b10 is ignored and count stays 4.
- Ordered dispatch: queue 2'b01, 2'b11. Drive fsm_state=DISP_A for one edge -> inp was 2'b01 before the edge and is 2'b11 after, count=1. Then fsm_state=DISP_B for one edge -> empty=1.
- Underflow: empty queue, fsm_state=DISP_B for one edge:
  - without the bypass macro: inp=2'b00, underflow=1, and it stays 1 after 10 more cycles;
  - with the bypass macro and push_valid=1, push_data=2'b10: inp=2'b10, count=0, underflow=0.
- Simultaneous push/pop:
  - count=2 with push and DISP_A on the same edge -> count=2, order preserved;
  - count=4 (full) with push_valid=1 and DISP_A -> push rejected, count=3.
- Wrap-around: 10 cycles with push and pop on every edge (DEPTH=4) -> popped sequence equals pushed sequence, and count never exceeds 2.

Source files
------------

// File: rtl/fsm_input_queue.sv
// Dispatch-code FIFO that feeds the microcoded sequencer's `inp` bus and pops once per dispatch state.
// Optional empty-queue bypass path is enabled by defining FSM_INPUT_QUEUE_BYPASS_EN.
module fsm_input_queue #(
    parameter int         DEPTH      = 4,
    parameter logic [3:0] DISP_A     = 4'b0011,
    parameter logic [3:0] DISP_B     = 4'b1010,
    parameter logic [1:0] EMPTY_CODE = 2'b00
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [1:0]                 push_data,
    output logic                       push_ready,
    input  logic [3:0]                 fsm_state,
    output logic [1:0]                 inp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop_req;
    logic          bypass_fire;
    logic          push_do;
    logic          pop_do;
    logic          underflow_set;

    assign pop_req    = (fsm_state == DISP_A) || (fsm_state == DISP_B);
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign push_ready = !full;

`ifdef FSM_INPUT_QUEUE_BYPASS_EN
    // An empty queue hands a fresh code straight to a dispatching sequencer.
    assign bypass_fire = empty && push_valid && pop_req;
`else
    assign bypass_fire = 1'b0;
`endif

    assign push_do       = push_valid && push_ready && !bypass_fire;
    assign pop_do        = pop_req && !empty;
    assign underflow_set = pop_req && empty && !bypass_fire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        inp = EMPTY_CODE;
        if (!empty) begin
            inp = mem[rd_ptr];
        end
`ifdef FSM_INPUT_QUEUE_BYPASS_EN
        else if (push_valid) begin
            inp = push_data;
        end
`endif
    end

    // NOTE: storage array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (push_do) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_do, pop_do})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (underflow_set) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_input_queue.sv
// Scoreboard bench for fsm_input_queue: driver queues expected codes, a negedge monitor checks each pop.
module tb_fsm_input_queue;

    localparam logic [3:0] DISP_A = 4'b0011;
    localparam logic [3:0] DISP_B = 4'b1010;
    localparam logic [3:0] IDLE   = 4'b0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_valid = 1'b0;
    logic [1:0] push_data = 2'b00;
    logic       push_ready;
    logic [3:0] fsm_state = IDLE;
    logic [1:0] inp;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q [$];

    fsm_input_queue #(
        .DEPTH(4), .DISP_A(DISP_A), .DISP_B(DISP_B), .EMPTY_CODE(2'b00)
    ) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data),
        .push_ready(push_ready), .fsm_state(fsm_state), .inp(inp), .count(count),
        .empty(empty), .full(full), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: an edge is about to pop when the state dispatches and the queue holds data.
    always @(negedge clk) begin
        if (!rst && ((fsm_state == DISP_A) || (fsm_state == DISP_B)) && !empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: got %0h expected none", inp);
            end else begin
                check("pop_data", 8'(inp), 8'(exp_q.pop_front()));
            end
        end
    end

    // One clock with given stimulus; accepted pushes are recorded as expected pops.
    task automatic cycle(input logic pv, input logic [1:0] pd, input logic [3:0] st, input logic accept);
        push_valid = pv;
        push_data  = pd;
        fsm_state  = st;
        if (pv && accept) exp_q.push_back(pd);
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        fsm_state  = IDLE;
    endtask

    initial begin
        #2;
        check("rst_empty", 8'(empty), 8'd1);
        check("rst_full", 8'(full), 8'd0);
        check("rst_ready", 8'(push_ready), 8'd1);
        check("rst_inp", 8'(inp), 8'd0);
        check("rst_count", 8'(count), 8'd0);
        check("rst_underflow", 8'(underflow), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Underflow on an empty queue
`ifdef FSM_INPUT_QUEUE_BYPASS_EN
        push_valid = 1'b1; push_data = 2'b10; fsm_state = DISP_B;
        #1;
        check("bypass_inp", 8'(inp), 8'b10);
        @(posedge clk); #1;
        push_valid = 1'b0; fsm_state = IDLE;
        check("bypass_count", 8'(count), 8'd0);
        check("bypass_underflow", 8'(underflow), 8'd0);
        cycle(1'b0, 2'b00, DISP_B, 1'b0);
`else
        fsm_state = DISP_B;
        #1;
        check("uf_inp", 8'(inp), 8'd0);
        @(posedge clk); #1;
        fsm_state = IDLE;
        check("uf_set", 8'(underflow), 8'd1);
`endif
        repeat (10) cycle(1'b0, 2'b00, IDLE, 1'b0);
        check("uf_sticky", 8'(underflow), 8'd1);
        check("uf_count", 8'(count), 8'd0);

        // Async reset mid-clock with 3 entries queued
        cycle(1'b1, 2'b01, IDLE, 1'b1);
        cycle(1'b1, 2'b10, IDLE, 1'b1);
        cycle(1'b1, 2'b11, IDLE, 1'b1);
        check("pre_rst_count", 8'(count), 8'd3);
        @(negedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_count", 8'(count), 8'd0);
        check("arst_empty", 8'(empty), 8'd1);
        check("arst_inp", 8'(inp), 8'd0);
        check("arst_underflow", 8'(underflow), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 2'b10, IDLE, 1'b1);
        check("post_rst_inp", 8'(inp), 8'b10);
        check("post_rst_count", 8'(count), 8'd1);
        cycle(1'b0, 2'b00, DISP_A, 1'b0);
        check("post_rst_drain", 8'(empty), 8'd1);

        // Fill and backpressure
        cycle(1'b1, 2'b01, IDLE, 1'b1);
        cycle(1'b1, 2'b10, IDLE, 1'b1);
        cycle(1'b1, 2'b11, IDLE, 1'b1);
        cycle(1'b1, 2'b01, IDLE, 1'b1);
        check("fill_full", 8'(full), 8'd1);
        check("fill_ready", 8'(push_ready), 8'd0);
        cycle(1'b1, 2'b10, IDLE, 1'b0);
        check("fill_reject_count", 8'(count), 8'd4);
        // Full with simultaneous push and dispatch: push still rejected
        cycle(1'b1, 2'b11, DISP_A, 1'b0);
        check("full_pushpop_count", 8'(count), 8'd3);
        repeat (3) cycle(1'b0, 2'b00, DISP_A, 1'b0);
        check("fill_drained", 8'(empty), 8'd1);

        // Ordered dispatch through both dispatch states
        cycle(1'b1, 2'b01, IDLE, 1'b1);
        cycle(1'b1, 2'b11, IDLE, 1'b1);
        check("ord_head", 8'(inp), 8'b01);
        cycle(1'b0, 2'b00, DISP_A, 1'b0);
        check("ord_next", 8'(inp), 8'b11);
        check("ord_count", 8'(count), 8'd1);
        cycle(1'b0, 2'b00, DISP_B, 1'b0);
        check("ord_empty", 8'(empty), 8'd1);

        // Push and pop together at count=2
        cycle(1'b1, 2'b10, IDLE, 1'b1);
        cycle(1'b1, 2'b01, IDLE, 1'b1);
        cycle(1'b1, 2'b11, DISP_A, 1'b1);
        check("pp_count", 8'(count), 8'd2);
        cycle(1'b0, 2'b00, DISP_B, 1'b0);
        cycle(1'b0, 2'b00, DISP_A, 1'b0);
        check("pp_empty", 8'(empty), 8'd1);

        // Wrap-around: push and pop on every edge
        cycle(1'b1, 2'b11, IDLE, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 2'(i), (i % 2 == 0) ? DISP_A : DISP_B, 1'b1);
            check("wrap_count_le2", 8'(count <= 3'd2), 8'd1);
        end
        cycle(1'b0, 2'b00, DISP_A, 1'b0);
        check("wrap_empty", 8'(empty), 8'd1);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
